uart_tx_frame_checker: RTL

- Parametrised successor to the print-only UART TX monitor.
- Passively samples the serial TX_OUT line and reconstructs each frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, stop bit.
- Checks parity and stop bit, reports each decoded frame with error flags, and keeps saturating frame and error counters.
- Sits beside the UART TX DUT in the bench, and optionally inside the design as an in-system line checker.

---
 rtl/uart_tx_frame_checker.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame_checker.sv
// Passive UART TX line checker: rebuilds each frame, flags parity/stop/busy errors, counts frames.
// Optional build macro UART_TX_BUSY_CHK_EN: require Busy high at every start/data/parity sample.
module uart_tx_frame_checker #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  TX_OUT,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  Busy,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  FRAME_VALID,
  output logic                  PAR_ERR,
  output logic                  STOP_ERR,
  output logic                  BUSY_ERR,
  output logic [CNT_WIDTH-1:0]  FRAME_CNT,
  output logic [CNT_WIDTH-1:0]  ERR_CNT
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW   = $clog2(DATA_WIDTH);
  localparam logic [TW-1:0] TIMER_FIRST = TW'((HALF == 0) ? (CLKS_PER_BIT - 1) : (HALF - 1));
  localparam logic [TW-1:0] TIMER_BIT   = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_e;

  // With one-cycle bits the start sample is the detection cycle itself, so START is skipped.
  localparam state_e FIRST_STATE = state_e'((HALF == 0) ? 3'd2 : 3'd1);

  state_e                  state_q, state_d;
  logic [TW-1:0]           timer_q;
  logic [BW-1:0]           bit_cnt_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    par_en_q, par_typ_q, par_err_q;
  logic                    tick_s, timed_s, start_s, shift_s, par_smp_s, done_s;
  logic                    frame_busy_s, frame_err_s;
  logic [DATA_WIDTH-1:0]   rx_data_q;
  logic                    frame_valid_q, par_flag_q, stop_flag_q, busy_flag_q;
  logic [CNT_WIDTH-1:0]    frame_cnt_q, err_cnt_q;

  assign tick_s      = (timer_q == '0);
  assign frame_err_s = par_err_q | ~TX_OUT | frame_busy_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!TX_OUT) state_d = FIRST_STATE; else state_d = IDLE;
      START:     if (tick_s) state_d = TX_OUT ? IDLE : DATA; else state_d = START;
      DATA: begin
        if (tick_s && (bit_cnt_q == LAST_BIT)) state_d = par_en_q ? PARITY : STOP;
        else state_d = DATA;
      end
      PARITY:    if (tick_s) state_d = STOP; else state_d = PARITY;
      STOP:      if (tick_s) state_d = TX_OUT ? IDLE : WAIT_HIGH; else state_d = STOP;
      WAIT_HIGH: if (TX_OUT) state_d = IDLE; else state_d = WAIT_HIGH;
      default:   state_d = IDLE;
    endcase
  end

  // FSM output strobes driving the datapath
  always_comb begin
    start_s   = 1'b0;
    timed_s   = 1'b0;
    shift_s   = 1'b0;
    par_smp_s = 1'b0;
    done_s    = 1'b0;
    case (state_q)
      IDLE:   start_s = ~TX_OUT;
      START:  timed_s = 1'b1;
      DATA:   begin timed_s = 1'b1; shift_s   = tick_s; end
      PARITY: begin timed_s = 1'b1; par_smp_s = tick_s; end
      STOP:   begin timed_s = 1'b1; done_s    = tick_s; end
      default: start_s = 1'b0;
    endcase
  end

  // Bit timer, data shifter and latched frame configuration
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      if (start_s) begin
        timer_q   <= TIMER_FIRST;
        bit_cnt_q <= '0;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        par_err_q <= 1'b0;
      end else if (timed_s) begin
        timer_q <= tick_s ? TIMER_BIT : (timer_q - TW'(1));
      end
      if (shift_s) begin
        data_q    <= {TX_OUT, data_q[DATA_WIDTH-1:1]};
        bit_cnt_q <= bit_cnt_q + BW'(1);
      end
      if (par_smp_s) par_err_q <= ((^data_q) ^ par_typ_q) != TX_OUT;
    end
  end

`ifdef UART_TX_BUSY_CHK_EN
  logic busy_err_q;
  logic busy_smp_s;

  assign busy_smp_s   = tick_s & timed_s & (state_q != STOP);
  assign frame_busy_s = busy_err_q;

  // Sticky busy error; the detection cycle is a sample point when bits are one cycle long
  always_ff @(posedge clk) begin
    if (reset)                    busy_err_q <= 1'b0;
    else if (start_s)             busy_err_q <= (HALF == 0) ? ~Busy : 1'b0;
    else if (busy_smp_s && !Busy) busy_err_q <= 1'b1;
    else                          busy_err_q <= busy_err_q;
  end
`else
  logic busy_unused_s;
  assign busy_unused_s = Busy;
  assign frame_busy_s  = 1'b0;
`endif

  // Frame report registers and saturating counters, updated the cycle after the stop sample
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_q     <= '0;
      frame_valid_q <= 1'b0;
      par_flag_q    <= 1'b0;
      stop_flag_q   <= 1'b0;
      busy_flag_q   <= 1'b0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      frame_valid_q <= done_s;
      if (done_s) begin
        rx_data_q   <= data_q;
        par_flag_q  <= par_err_q;
        stop_flag_q <= ~TX_OUT;
        busy_flag_q <= frame_busy_s;
        if (frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
        if (frame_err_s && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign RX_DATA     = rx_data_q;
  assign FRAME_VALID = frame_valid_q;
  assign PAR_ERR     = par_flag_q;
  assign STOP_ERR    = stop_flag_q;
  assign BUSY_ERR    = busy_flag_q;
  assign FRAME_CNT   = frame_cnt_q;
  assign ERR_CNT     = err_cnt_q;

endmodule
